// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, branch-stall state encoding and the hardwired-zero register index.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: freshest-value select for one branch operand plus its one- and two-cycle hazard flags.
module operand_fwd_mux
    import mips_pkg::REG_ZERO;
#(
    parameter int DATA_W = 32,
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              h1,
    output logic              h2
);
    logic nz, ex_m, mem_m, wb_m;
    always_comb begin
        nz = src != REG_ZERO;
        ex_m = nz & ex_regwrite & (ex_rd == src);
        mem_m = nz & mem_regwrite & (mem_rd == src);
        wb_m = nz & wb_regwrite & (wb_rd == src);
        // A load in MEM has no data yet, so it never feeds the comparator.
        fwd_data = (mem_m & ~mem_memread) ? mem_alu_result : wb_m ? wb_data : rf_data;
        h2 = ex_m & ex_memread;
        h1 = (ex_m & ~ex_memread) | (mem_m & mem_memread);
    end
endmodule

// File: rtl/branch_operand_unit.sv
// branch_operand_unit: ID-stage forwarding and 1/2-cycle stall control for the beq/bne comparator.
// Optional stall_count statistics port enabled by BRANCH_STALL_STATS_EN.
module branch_operand_unit #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_is_branch,
    input  logic              id_flush,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] cmp_data1,
    output logic [DATA_W-1:0] cmp_data2,
    output logic              stall
`ifdef BRANCH_STALL_STATS_EN
    ,output logic [31:0]      stall_count
`endif
);
    import mips_pkg::*;
    state_t state;
    logic h1_a, h2_a, h1_b, h2_b, active, h1, h2;
    operand_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src(id_rs), .rf_data(rf_data1),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_data(cmp_data1), .h1(h1_a), .h2(h2_a)
    );
    operand_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src(id_rt), .rf_data(rf_data2),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_data(cmp_data2), .h1(h1_b), .h2(h2_b)
    );
    always_comb begin
        active = id_is_branch & ~id_flush;
        h2 = active & (h2_a | h2_b);
        h1 = active & (h1_a | h1_b);
        stall = (state == HOLD) ? ~id_flush : (h1 | h2);
    end
    // A two-cycle load stall parks in HOLD for its second cycle; a flush there simply returns to IDLE.
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= (state == IDLE && h2) ? HOLD : IDLE;
`ifdef BRANCH_STALL_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) stall_count <= '0;
        else if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
`endif
endmodule

// File: tb/tb_branch_operand_unit.sv
// tb_branch_operand_unit: directed test-plan cases plus randomized traffic against a stall-budget reference model.
module tb_branch_operand_unit;
    logic clk = 0, reset = 0, id_is_branch = 0, id_flush = 0;
    logic [4:0] id_rs = 0, id_rt = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
    logic [31:0] rf_data1 = 0, rf_data2 = 0, mem_alu_result = 0, wb_data = 0;
    logic ex_regwrite = 0, ex_memread = 0, mem_regwrite = 0, mem_memread = 0, wb_regwrite = 0;
    logic [31:0] cmp_data1, cmp_data2;
    logic stall;
`ifdef BRANCH_STALL_STATS_EN
    logic [31:0] stall_count;
`endif
    int vecs = 0, errs = 0;
    int pend = 0;
    longint cnt = 0;
    logic exp_stall;
    branch_operand_unit dut (
        .clk(clk), .reset(reset), .id_is_branch(id_is_branch), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .cmp_data1(cmp_data1), .cmp_data2(cmp_data2), .stall(stall)
`ifdef BRANCH_STALL_STATS_EN
        , .stall_count(stall_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (mem_regwrite && !mem_memread && mem_rd == r) return mem_alu_result;
        if (wb_regwrite && wb_rd == r) return wb_data;
        return rf;
    endfunction
    // Cycles this operand must wait before its producer can forward to ID.
    function automatic int wait_cycles(input logic [4:0] r);
        if (r == 0) return 0;
        if (ex_regwrite && ex_rd == r) return ex_memread ? 2 : 1;
        if (mem_regwrite && mem_memread && mem_rd == r) return 1;
        return 0;
    endfunction
    function automatic int need();
        int a, b;
        if (!id_is_branch || id_flush) return 0;
        a = wait_cycles(id_rs);
        b = wait_cycles(id_rt);
        return a > b ? a : b;
    endfunction
    task automatic check_now(input string tag);
        exp_stall = pend > 0 ? !id_flush : need() > 0;
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        check({tag, ".cmp1"}, cmp_data1, ref_fwd(id_rs, rf_data1));
        check({tag, ".cmp2"}, cmp_data2, ref_fwd(id_rt, rf_data2));
`ifdef BRANCH_STALL_STATS_EN
        check({tag, ".count"}, stall_count, cnt > 32'hFFFF_FFFF ? 32'hFFFF_FFFF : cnt[31:0]);
`endif
    endtask
    task automatic tick();
        int n;
        n = need();
        exp_stall = pend > 0 ? !id_flush : n > 0;
        if (reset) begin
            pend = 0;
            cnt = 0;
        end else begin
            if (exp_stall) cnt++;
            pend = (pend == 0 && n == 2) ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic clear_writers();
        ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0; wb_regwrite = 0;
        id_flush = 0;
    endtask
    task automatic do_reset();
        reset = 1;
        pend = 0;
        cnt = 0;
        #1;
        check_now("reset");
        tick();
        reset = 0;
    endtask
    initial begin
        #1;
        do_reset();
        check("reset_stall", {31'd0, stall}, 32'd0);
        id_is_branch = 1; id_rs = 3; id_rt = 4; rf_data1 = 24; rf_data2 = 24;
        ex_regwrite = 1; ex_rd = 7; #1;
        check_now("nohaz");
        check("nohaz_stall", {31'd0, stall}, 32'd0);
        check("nohaz_cmp", cmp_data1 ^ cmp_data2, 32'd0);
        clear_writers();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 3; #1;
        check_now("exld1");
        check("exld1_stall", {31'd0, stall}, 32'd1);
        tick();
        clear_writers(); mem_regwrite = 1; mem_memread = 1; mem_rd = 3; #1;
        check_now("exld2");
        check("exld2_stall", {31'd0, stall}, 32'd1);
        tick();
        clear_writers(); wb_regwrite = 1; wb_rd = 3; wb_data = 78; #1;
        check_now("exld3");
        check("exld3_stall", {31'd0, stall}, 32'd0);
        check("exld3_cmp1", cmp_data1, 32'd78);
        tick();
        clear_writers(); ex_regwrite = 1; ex_rd = 4; #1;
        check_now("exalu1");
        tick();
        clear_writers(); mem_regwrite = 1; mem_rd = 4; mem_alu_result = 52; #1;
        check_now("exalu2");
        check("exalu2_stall", {31'd0, stall}, 32'd0);
        check("exalu2_cmp2", cmp_data2, 32'd52);
        tick();
        clear_writers(); mem_regwrite = 1; mem_rd = 3; mem_alu_result = 11;
        wb_regwrite = 1; wb_rd = 3; wb_data = 99; #1;
        check_now("prio");
        check("prio_cmp1", cmp_data1, 32'd11);
        tick();
        clear_writers(); id_rs = 0; rf_data1 = 32'h55; ex_regwrite = 1; ex_memread = 1; ex_rd = 0; #1;
        check_now("zero");
        check("zero_stall", {31'd0, stall}, 32'd0);
        check("zero_cmp1", cmp_data1, 32'h55);
        tick();
        do_reset();
        clear_writers(); id_rs = 3; ex_regwrite = 1; ex_memread = 1; ex_rd = 3; #1;
        check_now("flush1");
        tick();
        clear_writers(); id_flush = 1; #1;
        check_now("flush2");
        check("flush2_stall", {31'd0, stall}, 32'd0);
        tick();
        id_flush = 0; #1;
        check_now("flush3");
        check("flush3_stall", {31'd0, stall}, 32'd0);
`ifdef BRANCH_STALL_STATS_EN
        check("flush_count", stall_count, 32'd1);
`endif
        tick();
        clear_writers(); ex_regwrite = 1; ex_memread = 1; ex_rd = 3; #1;
        check_now("rst1");
        tick();
        clear_writers(); #1;
        check_now("rst2");
        check("rst2_stall", {31'd0, stall}, 32'd1);
        reset = 1; pend = 0; cnt = 0; #1;
        check_now("rst_mid");
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
`ifdef BRANCH_STALL_STATS_EN
        check("rst_mid_count", stall_count, 32'd0);
`endif
        tick();
        reset = 0;
        for (int i = 0; i < 400; i++) begin
            id_is_branch = $urandom_range(0, 3) != 0;
            id_flush = $urandom_range(0, 7) == 0;
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
            mem_regwrite = 1'($urandom); mem_memread = 1'($urandom); wb_regwrite = 1'($urandom);
            rf_data1 = $urandom; rf_data2 = $urandom; mem_alu_result = $urandom; wb_data = $urandom;
            reset = $urandom_range(0, 49) == 0;
            if (reset) begin
                pend = 0;
                cnt = 0;
            end
            #1;
            check_now("rand");
            tick();
        end
        reset = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/branch_operand_unit.md
# branch_operand_unit

ID-stage hazard and forwarding unit that sits directly upstream of the branch equality comparator in the pipelined MIPS core. For `beq`/`bne` in ID, it picks the freshest value of `rs` and `rt` from the register file, EX/MEM or MEM/WB and drives them onto the comparator's `data1`/`data2`. When a needed value is not yet produced, it stalls the front end with a small state machine, for 1 or 2 cycles.

## Interface
Parameters:
- `DATA_W`, 32, operand width
- `REG_W`, 5, register index width

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `id_is_branch`  in  1  ID instruction is beq/bne
- `id_flush`  in  1  ID instruction is being squashed this cycle
- `id_rs`, `id_rt`  in  REG_W  branch source registers
- `rf_data1`, `rf_data2`  in  DATA_W  register file read data
- `ex_regwrite`, `ex_memread`  in  1  ID/EX control
- `ex_rd`  in  REG_W  ID/EX destination
- `mem_regwrite`, `mem_memread`  in  1  EX/MEM control
- `mem_rd`  in  REG_W  EX/MEM destination
- `mem_alu_result`  in  DATA_W  EX/MEM ALU result
- `wb_regwrite`  in  1  MEM/WB control
- `wb_rd`  in  REG_W  MEM/WB destination
- `wb_data`  in  DATA_W  MEM/WB write-back value
- `cmp_data1`, `cmp_data2`  out  DATA_W  operands to comparator
- `stall`  out  1  hold PC and IF/ID, insert bubble into ID/EX
- `stall_count`  out  32  stall-cycle counter (only with `BRANCH_STALL_STATS_EN`)

## Operation
- Match condition: writer's regwrite is 1, its dest equals the source register, and the source register is not $0. $0 never matches.
- Forwarding, per operand, in priority order:
  - MEM non-load match (`mem_regwrite & !mem_memread`): use `mem_alu_result`.
  - Else WB match: use `wb_data`.
  - Else: use `rf_data`.
- Forwarding muxes are purely combinational and active whether or not `id_is_branch` is set.
- Hazard classes, evaluated only when `id_is_branch & !id_flush`:
  - H2: EX load match on either operand.
  - H1: EX non-load match, or MEM load match, on either operand.
  - If both apply, H2 wins.
- FSM states:
  - IDLE:
    - H2: `stall`=1, next HOLD.
    - H1: `stall`=1, stay IDLE. Next cycle is re-evaluated and the hazard has cleared.
    - None: `stall`=0.
  - HOLD: `stall`=1 unconditionally, next IDLE.
    - Exception: `id_flush`=1 in HOLD gives `stall`=0 and next IDLE (abort).
- `id_flush` in IDLE suppresses stall.

## Timing
- `cmp_data*` follow their inputs with zero latency.
- `stall` is combinational from state and inputs. It asserts in the same cycle the hazard is detected.
- Stall lengths:
  - EX load dependency: exactly 2 stall cycles. The operand then comes from `wb_data`.
  - EX ALU dependency: 1 cycle. The operand then comes from `mem_alu_result`.
  - MEM load dependency: 1 cycle. The operand then comes from `wb_data`.
- Reset: state=IDLE and `stall_count`=0, applied immediately. `stall` follows combinationally; with no hazard it is 0. Reset during HOLD aborts the stall.
- Upstream keeps `id_*` stable while `stall`=1, because IF/ID is held.

## Configuration
- `BRANCH_STALL_STATS_EN` defined:
  - `stall_count` increments on every cycle with `stall`=1.
  - It saturates at 0xFFFFFFFF and is cleared by reset.
- Undefined: the `stall_count` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_W` and `REG_W`
  - state typedef (IDLE, HOLD)
  - `REG_ZERO` constant
- One sub-module, `operand_fwd_mux`, instantiated twice. It does the per-operand match/priority select and returns the forwarded value plus the H1/H2 match flags.

## Test plan
- No hazard:
  - Stimulus: `id_rs`=3, `id_rt`=4, `rf_data1`=`rf_data2`=24, no writer matches.
  - Response: `stall`=0, comparator sees 24/24.
- EX load hazard:
  - Stimulus: `ex_memread`=1, `ex_regwrite`=1, `ex_rd`=3, branch on `id_rs`=3. Next cycles advance the load to MEM, then to WB with `wb_data`=78.
  - Response: `stall`=1 for 2 cycles. Third cycle `stall`=0, `cmp_data1`=78.
- EX ALU hazard:
  - Stimulus: `ex_rd`=4, non-load. Next cycle `mem_rd`=4, `mem_alu_result`=52.
  - Response: 1 stall cycle, then `cmp_data2`=52.
- Priority:
  - Stimulus: MEM non-load match (value 11) and WB match (value 99) on the same register.
  - Response: `cmp_data1`=11.
- $0 source:
  - Stimulus: `id_rs`=0, `ex_rd`=0 load.
  - Response: no stall, `cmp_data1`=`rf_data1`.
- Aborts and statistics:
  - Stimulus: `id_flush` raised in HOLD; separately, `reset` pulsed mid-stall.
  - Response: `stall` drops the same cycle, state=IDLE. With the macro, `stall_count` counts 1 for the flushed H2 case and is 0 after reset.
